// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_tx
// Purpose  : Multi-channel serial audio transmitter and bus master. It derives
//            lrclk and sdata from sclk in I2S, left-justified, right-justified
//            or DSP/TDM framing. Frames enter through a valid/ready handshake
//            into a one-frame holding buffer. A frame start that finds the
//            holding buffer empty sends a zero frame and pulses underrun.
// Ports    : sclk        bit clock; every state update is on its falling edge
//            rst         asynchronous reset, active-high
//            en          transmitter enable
//            fmt         0 I2S, 1 left-justified, 2 right-justified, 3 DSP/TDM
//            in_data     one frame; slot k at [(k+1)*AUDIO_DW-1 : k*AUDIO_DW]
//            in_valid    in_data is valid
//            in_ready    holding buffer empty
//            lrclk       frame sync
//            sdata       serial data, MSB first
//            frame_start one-cycle pulse while slot 0, bit 0 is driven
//            underrun    one-cycle pulse at a frame start with no frame held
// Option   : define I2S_TDM_REPEAT_ON_UNDERRUN_EN to retransmit the previous
//            frame on underrun instead of sending zeros.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tdm_tx #(
  parameter int AUDIO_DW = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   fmt,
  input  logic [CHANNELS*AUDIO_DW-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int c_BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int c_SW = $clog2(CHANNELS);
  localparam int c_FW = CHANNELS * AUDIO_DW;
  localparam logic [c_BW-1:0] c_B_LAST  = c_BW'(SLOT_W - 1);
  localparam logic [c_SW-1:0] c_S_LAST  = c_SW'(CHANNELS - 1);
  localparam logic [1:0]      c_FMT_I2S = 2'd0;
  localparam logic [1:0]      c_FMT_LJ  = 2'd1;
  localparam logic [1:0]      c_FMT_RJ  = 2'd2;
  localparam logic [1:0]      c_FMT_DSP = 2'd3;

  logic [c_BW-1:0]     r_b;
  logic [c_SW-1:0]     r_s;
  logic [1:0]          r_fmt;
  logic [c_FW-1:0]     r_hold;
  logic                r_hold_full;
  logic [c_FW-1:0]     r_active;
  logic                r_dly;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_fs;
  logic                r_ur;

  logic                w_fs;
  logic [1:0]          w_fmt;
  logic [c_FW-1:0]     w_active;
  logic [AUDIO_DW-1:0] w_word;
  int                  w_idx;
  logic                w_l;
  logic                w_upper;
  logic                w_lr;
  logic                w_sd;

  // At a frame start the newly latched fmt and the newly selected frame must
  // already govern the bit driven on that same edge, so bypass the registers.
  always_comb begin
    w_fs     = en && (r_b == '0) && (r_s == '0);
    w_fmt    = w_fs ? fmt : r_fmt;
    w_active = r_active;
    if (w_fs) begin
      if (r_hold_full) begin
        w_active = r_hold;
      end else begin
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
        w_active = r_active;
`else
        w_active = '0;
`endif
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(r_s) == k) w_word = w_active[k*AUDIO_DW +: AUDIO_DW];
    end
  end

  // Sample bit index for the current slot position; an index outside
  // 0..AUDIO_DW-1 is padding and drives 0. Right-justified aligns the LSB to
  // the last bit of the slot, all other formats align the MSB to bit 0.
  always_comb begin
    w_idx = (w_fmt == c_FMT_RJ) ? (SLOT_W - 1 - int'(r_b))
                                : (AUDIO_DW - 1 - int'(r_b));
    w_l   = 1'b0;
    for (int j = 0; j < AUDIO_DW; j++) begin
      if (w_idx == j) w_l = w_word[j];
    end
  end

  always_comb begin
    w_upper = (int'(r_s) >= (CHANNELS / 2));
    case (w_fmt)
      c_FMT_I2S: w_lr = w_upper;
      c_FMT_DSP: w_lr = w_fs;
      default:   w_lr = ~w_upper;
    endcase
    // I2S and DSP take the one-bit-late copy of the base stream.
    w_sd = ((w_fmt == c_FMT_LJ) || (w_fmt == c_FMT_RJ)) ? w_l : r_dly;
  end

  always_ff @(negedge sclk or posedge rst) begin
    if (rst) begin
      r_b         <= '0;
      r_s         <= '0;
      r_fmt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_active    <= '0;
      r_dly       <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_fs        <= 1'b0;
      r_ur        <= 1'b0;
    end else begin
      // Accepting and consuming are mutually exclusive: accept needs the
      // holding buffer empty, consume needs it full.
      if (in_valid && !r_hold_full) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
      if (!en) begin
        r_b     <= '0;
        r_s     <= '0;
        r_dly   <= 1'b0;
        r_lrclk <= 1'b0;
        r_sdata <= 1'b0;
        r_fs    <= 1'b0;
        r_ur    <= 1'b0;
      end else begin
        if (w_fs) begin
          r_fmt    <= fmt;
          r_active <= w_active;
          if (r_hold_full) r_hold_full <= 1'b0;
        end
        r_ur    <= w_fs && !r_hold_full;
        r_fs    <= w_fs;
        r_lrclk <= w_lr;
        r_sdata <= w_sd;
        r_dly   <= w_l;
        if (r_b == c_B_LAST) begin
          r_b <= '0;
          r_s <= (r_s == c_S_LAST) ? '0 : r_s + 1'b1;
        end else begin
          r_b <= r_b + 1'b1;
        end
      end
    end
  end

  assign in_ready    = ~r_hold_full;
  assign lrclk       = r_lrclk;
  assign sdata       = r_sdata;
  assign frame_start = r_fs;
  assign underrun    = r_ur;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tdm_tx
// Purpose  : Self-checking bench for i2s_tdm_tx. A frame-level model predicts
//            every output of the 2-channel instance on every sclk cycle, and
//            directed captures pin the model with hand-computed words. A
//            second 8-channel DSP/TDM instance is checked by deserializing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_tx;

  localparam int AW    = 24;
  localparam int SW    = 32;
  localparam int CH    = 2;
  localparam int FRAME = CH * SW;
  localparam int CH8   = 8;
  localparam int FRAME8 = CH8 * SW;

  logic sclk = 1'b0;
  logic rst, en, in_valid;
  logic [1:0] fmt;
  logic [CH*AW-1:0] in_data;
  logic in_ready, lrclk, sdata, frame_start, underrun;

  logic en8, in_valid8;
  logic [1:0] fmt8;
  logic [CH8*AW-1:0] in_data8;
  logic in_ready8, lrclk8, sdata8, frame_start8, underrun8;

  int n_pass = 0;
  int n_total = 0;

  always #5 sclk = ~sclk;

  i2s_tdm_tx #(.AUDIO_DW(AW), .SLOT_W(SW), .CHANNELS(CH)) u_dut (
    .sclk(sclk), .rst(rst), .en(en), .fmt(fmt), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .lrclk(lrclk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_tdm_tx #(.AUDIO_DW(AW), .SLOT_W(SW), .CHANNELS(CH8)) u_dut8 (
    .sclk(sclk), .rst(rst), .en(en8), .fmt(fmt8), .in_data(in_data8),
    .in_valid(in_valid8), .in_ready(in_ready8), .lrclk(lrclk8), .sdata(sdata8),
    .frame_start(frame_start8), .underrun(underrun8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level model of the 2-channel instance ------------
  int          m_pos;
  logic        m_full, m_rdy_pre, m_prev, m_bit;
  logic [1:0]  m_fmt;
  logic [CH*AW-1:0] m_hold, m_cur;
  logic e_lr, e_sd, e_fs, e_ur, e_rdy;

  // Bit at slot position b: the sample sits in a window of AW bits whose
  // first bit is 0 (MSB-aligned) or SW-AW (LSB-aligned for right-justified).
  function automatic logic base_bit(input logic [CH*AW-1:0] fr, input int s,
                                    input int b, input logic [1:0] f);
    logic [AW-1:0] w;
    int start;
    w = fr[s*AW +: AW];
    start = (f == 2'd2) ? (SW - AW) : 0;
    if (b < start || b >= start + AW) return 1'b0;
    return w[AW-1-(b-start)];
  endfunction

  always @(negedge sclk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_full = 1'b0; m_hold = '0; m_cur = '0; m_fmt = 2'd0;
      m_prev = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
      e_rdy = 1'b1;
    end else begin
      m_rdy_pre = !m_full;
      if (!en) begin
        m_pos = 0; m_prev = 1'b0;
        e_lr = 1'b0; e_sd = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
      end else begin
        e_fs = (m_pos == 0);
        e_ur = 1'b0;
        if (m_pos == 0) begin
          m_fmt = fmt;
          if (m_full) begin
            m_cur  = m_hold;
            m_full = 1'b0;
          end else begin
            e_ur = 1'b1;
`ifndef I2S_TDM_REPEAT_ON_UNDERRUN_EN
            m_cur = '0;
`endif
          end
        end
        m_bit = base_bit(m_cur, m_pos / SW, m_pos % SW, m_fmt);
        e_sd  = (m_fmt == 2'd1 || m_fmt == 2'd2) ? m_bit : m_prev;
        m_prev = m_bit;
        if (m_fmt == 2'd3) e_lr = (m_pos == 0);
        else               e_lr = ((m_pos / SW) >= CH / 2) ^ (m_fmt != 2'd0);
        m_pos = (m_pos + 1) % FRAME;
      end
      if (in_valid && m_rdy_pre) begin
        m_hold = in_data;
        m_full = 1'b1;
      end
      e_rdy = !m_full;
    end
  end

  // Compare process: outputs change on the falling edge, sample on the rising.
  always @(posedge sclk) begin
    if (!rst) begin
      check("m_lrclk", {31'd0, lrclk}, {31'd0, e_lr});
      check("m_sdata", {31'd0, sdata}, {31'd0, e_sd});
      check("m_frame_start", {31'd0, frame_start}, {31'd0, e_fs});
      check("m_underrun", {31'd0, underrun}, {31'd0, e_ur});
      check("m_in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    end
  end

  // ---------------- directed capture helpers -------------------------------
  logic cap_lr [0:FRAME-1];
  logic cap_sd [0:FRAME-1];
  logic cap_ur [0:FRAME-1];
  logic cap8_lr [0:FRAME8-1];
  logic cap8_sd [0:FRAME8-1];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic cap_frame(output int waited);
    waited = 0;
    while (frame_start !== 1'b1 && waited < 3*FRAME) begin
      tick();
      waited++;
    end
    check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      cap_lr[i] = lrclk;
      cap_sd[i] = sdata;
      cap_ur[i] = underrun;
      if (i < FRAME-1) tick();
    end
  endtask

  function automatic logic [31:0] slot_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < SW; i++) w = {w[30:0], cap_sd[k*SW+i]};
    return w;
  endfunction

  function automatic int count_lr();
    int c;
    c = 0;
    for (int i = 0; i < FRAME; i++) c += int'(cap_lr[i]);
    return c;
  endfunction

  function automatic int count_ur();
    int c;
    c = 0;
    for (int i = 0; i < FRAME; i++) c += int'(cap_ur[i]);
    return c;
  endfunction

  task automatic cap_frame8();
    int waited;
    int c;
    logic [AW-1:0] w;
    waited = 0;
    while (frame_start8 !== 1'b1 && waited < 3*FRAME8) begin
      tick();
      waited++;
    end
    check("tdm8_frame_start_seen", {31'd0, frame_start8}, 32'd1);
    for (int i = 0; i < FRAME8; i++) begin
      cap8_lr[i] = lrclk8;
      cap8_sd[i] = sdata8;
      if (i < FRAME8-1) tick();
    end
    c = 0;
    for (int i = 0; i < FRAME8; i++) c += int'(cap8_lr[i]);
    check("tdm8_lrclk_high_count", c, 32'd1);
    check("tdm8_lrclk_at_start", {31'd0, cap8_lr[0]}, 32'd1);
    for (int k = 0; k < CH8; k++) begin
      w = '0;
      for (int i = 1; i <= AW; i++) w = {w[AW-2:0], cap8_sd[k*SW+i]};
      check($sformatf("tdm8_slot%0d", k), {8'd0, w}, k + 1);
    end
  endtask

  // ---------------- directed sequence --------------------------------------
  int waited;

  initial begin
    rst = 1'b1; en = 1'b0; fmt = 2'd0; in_valid = 1'b0; in_data = '0;
    en8 = 1'b0; fmt8 = 2'd3; in_valid8 = 1'b0;
    for (int k = 0; k < CH8; k++) in_data8[k*AW +: AW] = AW'(k + 1);
    #2;
    check("rst_lrclk", {31'd0, lrclk}, 32'd0);
    check("rst_sdata", {31'd0, sdata}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    // I2S, L=AAAAAA R=555555 supplied continuously; loaded while disabled.
    in_data = {24'h555555, 24'hAAAAAA};
    in_valid = 1'b1; in_valid8 = 1'b1;
    repeat (4) tick();
    check("disabled_accepts", {31'd0, in_ready}, 32'd0);
    en = 1'b1; en8 = 1'b1;
    cap_frame(waited);
    check("i2s_slot0_word", slot_word(0), 32'h5555_5500);
    check("i2s_slot1_word", slot_word(1), 32'h2AAA_AA80);
    check("i2s_lrclk_high_count", count_lr(), 32'd32);
    check("i2s_lrclk_start", {31'd0, cap_lr[0]}, 32'd0);
    check("i2s_lrclk_slot1", {31'd0, cap_lr[32]}, 32'd1);
    check("i2s_no_underrun", count_ur(), 32'd0);

    cap_frame8();

    // Left-justified, L=800001.
    fmt = 2'd1; in_data = {24'h000000, 24'h800001};
    cap_frame(waited);
    cap_frame(waited);
    check("lj_slot0_word", slot_word(0), 32'h8000_0100);
    check("lj_slot1_word", slot_word(1), 32'h0);
    check("lj_lrclk_start", {31'd0, cap_lr[0]}, 32'd1);
    check("lj_lrclk_end", {31'd0, cap_lr[FRAME-1]}, 32'd0);
    check("lj_lrclk_high_count", count_lr(), 32'd32);

    // Right-justified, L=FFFFFF.
    fmt = 2'd2; in_data = {24'h000000, 24'hFFFFFF};
    cap_frame(waited);
    cap_frame(waited);
    check("rj_slot0_word", slot_word(0), 32'h00FF_FFFF);

    // Underrun: one good frame, then in_valid withheld for one frame.
    fmt = 2'd1; in_data = {24'h654321, 24'h123456};
    cap_frame(waited);
    cap_frame(waited);
    check("lj2_slot0_word", slot_word(0), 32'h1234_5600);
    check("lj2_slot1_word", slot_word(1), 32'h6543_2100);
    in_valid = 1'b0;
    cap_frame(waited);
    check("last_frame_no_underrun", count_ur(), 32'd0);
    check("last_frame_slot0", slot_word(0), 32'h1234_5600);
    cap_frame(waited);
    check("underrun_at_frame_start", {31'd0, cap_ur[0]}, 32'd1);
    check("underrun_single_cycle", count_ur(), 32'd1);
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
    check("underrun_frame_slot0", slot_word(0), 32'h1234_5600);
`else
    check("underrun_frame_slot0", slot_word(0), 32'h0);
`endif

    // Back to I2S data, then reset mid-frame at slot 1, bit 10.
    fmt = 2'd0; in_data = {24'h555555, 24'hAAAAAA};
    in_valid = 1'b1;
    cap_frame(waited);
    cap_frame(waited);
    tick();
    check("next_frame_start", {31'd0, frame_start}, 32'd1);
    repeat (SW + 10) tick();
    check("pre_rst_lrclk", {31'd0, lrclk}, 32'd1);
    check("pre_rst_sdata", {31'd0, sdata}, 32'd1);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_lrclk", {31'd0, lrclk}, 32'd0);
    check("async_rst_sdata", {31'd0, sdata}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("async_rst_underrun", {31'd0, underrun}, 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cap_frame(waited);
    check("post_rst_first_edge_frame", waited, 32'd1);
    check("post_rst_underrun", {31'd0, cap_ur[0]}, 32'd1);
    check("post_rst_slot0", slot_word(0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
